// File: rtl/tx_medida_serial.sv
// Serial transmitter for the BCD distance: three ASCII digits followed by '#'.
// Outputs are registered one cycle behind the FSM state; each bit holds for DIVISOR cycles.
// Requests arriving while a frame is in flight are dropped. Optional even parity (8E1) when TX_MEDIDA_PARIDADE_EN is defined.
module tx_medida_serial #(
  parameter int DIVISOR = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enviar,
  input  logic [11:0] medida,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam int CNT_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

`ifdef TX_MEDIDA_PARIDADE_EN
  typedef enum logic [3:0] {
    REPOUSO  = 4'd0,
    CARREGA  = 4'd1,
    INICIO   = 4'd2,
    DADOS    = 4'd3,
    PARADA   = 4'd4,
    PROXIMO  = 4'd5,
    FIM      = 4'd6,
    PARIDADE = 4'd7
  } estado_t;
`else
  typedef enum logic [3:0] {
    REPOUSO  = 4'd0,
    CARREGA  = 4'd1,
    INICIO   = 4'd2,
    DADOS    = 4'd3,
    PARADA   = 4'd4,
    PROXIMO  = 4'd5,
    FIM      = 4'd6
  } estado_t;
`endif

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       idx_q, idx_d;
  logic [11:0]      dig_q, dig_d;
  logic             linha_q, linha_d;
  logic             ocupado_q, ocupado_d;
  logic             pronto_q, pronto_d;

  logic [7:0]       caractere;
  logic             tick;
  logic [CNT_W-1:0] cnt_prox;

  // Character selected by the index: ASCII '0' plus the raw nibble, then '#'.
  always_comb begin
    caractere = 8'h23;
    case (idx_q)
      2'd0:    caractere = 8'h30 + {4'h0, dig_q[11:8]};
      2'd1:    caractere = 8'h30 + {4'h0, dig_q[7:4]};
      2'd2:    caractere = 8'h30 + {4'h0, dig_q[3:0]};
      default: caractere = 8'h23;
    endcase
  end

  // Bit-time counter runs 0..DIVISOR-1 and wraps on each bit boundary.
  assign tick     = (cnt_q == CNT_MAX);
  assign cnt_prox = tick ? '0 : cnt_q + CNT_W'(1);

  // Next-state, datapath and next-output logic.
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    dig_d     = dig_q;
    linha_d   = 1'b1;
    ocupado_d = 1'b1;
    pronto_d  = 1'b0;
    case (estado_q)
      REPOUSO: begin
        ocupado_d = 1'b0;
        cnt_d     = '0;
        bit_d     = '0;
        if (enviar) begin
          // Digits captured on acceptance so later changes cannot leak in.
          dig_d    = medida;
          idx_d    = '0;
          estado_d = CARREGA;
        end
      end
      CARREGA: begin
        idx_d    = '0;
        cnt_d    = '0;
        bit_d    = '0;
        estado_d = INICIO;
      end
      INICIO: begin
        linha_d = 1'b0;
        cnt_d   = cnt_prox;
        if (tick) begin
          bit_d    = '0;
          estado_d = DADOS;
        end
      end
      DADOS: begin
        linha_d = caractere[bit_q];
        cnt_d   = cnt_prox;
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef TX_MEDIDA_PARIDADE_EN
            estado_d = PARIDADE;
`else
            estado_d = PARADA;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef TX_MEDIDA_PARIDADE_EN
      PARIDADE: begin
        linha_d = ^caractere;
        cnt_d   = cnt_prox;
        if (tick) estado_d = PARADA;
      end
`endif
      PARADA: begin
        cnt_d = cnt_prox;
        if (tick) estado_d = (idx_q == 2'd3) ? FIM : PROXIMO;
      end
      PROXIMO: begin
        idx_d    = idx_q + 2'd1;
        cnt_d    = '0;
        estado_d = INICIO;
      end
      FIM: begin
        ocupado_d = 1'b0;
        pronto_d  = 1'b1;
        estado_d  = REPOUSO;
      end
      default: begin
        ocupado_d = 1'b0;
        cnt_d     = '0;
        estado_d  = REPOUSO;
      end
    endcase
  end

  // State, datapath and output registers; the line idles high out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= REPOUSO;
      cnt_q     <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      dig_q     <= '0;
      linha_q   <= 1'b1;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      dig_q     <= dig_d;
      linha_q   <= linha_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign saida_serial = linha_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_tx_medida_serial.sv
// Bench for tx_medida_serial with DIVISOR = 4: table of frames plus reset sequences.
// Line, ocupado and pronto are recorded per cycle relative to the enviar sample edge.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tx_medida_serial;

  localparam int D = 4;
`ifdef TX_MEDIDA_PARIDADE_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int STRIDE     = NB * D + 1;
  localparam int PRONTO_OFS = 2 + 4 * NB * D + 3;
  localparam int WIN        = PRONTO_OFS + 20;

  logic        clock = 1'b0;
  logic        reset;
  logic        enviar;
  logic [11:0] medida;
  logic        saida_serial;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  tx_medida_serial #(.DIVISOR(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .enviar       (enviar),
    .medida       (medida),
    .saida_serial (saida_serial),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic hl [0:WIN-1];
  logic ho [0:WIN-1];
  logic hp [0:WIN-1];
  logic [3:0] hs0;

  typedef struct {
    logic [11:0]      med;
    logic [11:0]      late;
    int               rep;
    logic [3:0][7:0]  ex;
  } vec_t;

  vec_t vt [5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] ch;
    logic       b;
    int s, werr, ferr, perr, npr, ofs, idle_low;
    @(negedge clock);
    medida = v.med;
    enviar = 1'b1;
    for (int n = 0; n < WIN; n++) begin
      @(negedge clock);
      hl[n] = saida_serial;
      ho[n] = ocupado;
      hp[n] = pronto;
      if (n == 0) hs0 = db_estado;
      if (n == 0) enviar = 1'b0;
      if (n == 1) medida = v.late;
      if (v.rep > 0 && n == v.rep) enviar = 1'b1;
      if (v.rep > 0 && n == v.rep + 1) enviar = 1'b0;
    end
    werr = 0; ferr = 0; perr = 0;
    if (hl[1] !== 1'b1) ferr++;
    for (int c = 0; c < 4; c++) begin
      s  = 2 + c * STRIDE;
      ch = '0;
      for (int j = 0; j < NB; j++) begin
        b = hl[s + j * D];
        for (int d = 1; d < D; d++)
          if (hl[s + j * D + d] !== b) werr++;
        if (j == 0 && b !== 1'b0) ferr++;
        if (j >= 1 && j <= 8) ch[j-1] = b;
        if (NB == 11 && j == 9 && b !== ^v.ex[c]) perr++;
        if (j == NB - 1 && b !== 1'b1) ferr++;
      end
      if (c < 3 && hl[s + NB * D] !== 1'b1) ferr++;
      check($sformatf("%s char%0d", tag, c), int'(ch), int'(v.ex[c]));
    end
    npr = 0; ofs = -1; idle_low = 0;
    for (int n = 0; n < WIN; n++) begin
      if (hp[n] === 1'b1) begin
        npr++;
        if (ofs < 0) ofs = n;
      end
      if (n >= PRONTO_OFS && hl[n] !== 1'b1) idle_low++;
    end
    check({tag, " bitwidth_errs"}, werr, 0);
    check({tag, " framing_errs"}, ferr, 0);
    check({tag, " parity_errs"}, perr, 0);
    check({tag, " db_estado_carrega"}, int'(hs0), 1);
    check({tag, " pronto_count"}, npr, 1);
    check({tag, " pronto_offset"}, ofs, PRONTO_OFS);
    check({tag, " ocupado_before_end"}, int'(ho[PRONTO_OFS-1]), 1);
    check({tag, " ocupado_at_pronto"}, int'(ho[PRONTO_OFS]), 0);
    check({tag, " idle_after_frame"}, idle_low, 0);
  endtask

  initial begin
    int lows, busy, npr, target;

    vt[0] = '{12'h123, 12'h123, 0,  {8'h23, 8'h33, 8'h32, 8'h31}};
    vt[1] = '{12'h045, 12'h999, 0,  {8'h23, 8'h35, 8'h34, 8'h30}};
    vt[2] = '{12'h123, 12'h123, 2 + STRIDE + 20, {8'h23, 8'h33, 8'h32, 8'h31}};
    vt[3] = '{12'h9A0, 12'h9A0, 0,  {8'h23, 8'h30, 8'h3A, 8'h39}};
    vt[4] = '{12'hFFF, 12'h000, 0,  {8'h23, 8'h3F, 8'h3F, 8'h3F}};

    // Reset idle state.
    reset  = 1'b1;
    enviar = 1'b0;
    medida = 12'h000;
    #2;
    check("rst saida_serial", int'(saida_serial), 1);
    check("rst ocupado", int'(ocupado), 0);
    check("rst pronto", int'(pronto), 0);
    check("rst db_estado", int'(db_estado), 0);
    @(negedge clock);
    reset = 1'b0;
    lows = 0; busy = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (saida_serial !== 1'b1) lows++;
      if (ocupado !== 1'b0 || pronto !== 1'b0) busy++;
    end
    check("idle line_low_cycles", lows, 0);
    check("idle busy_cycles", busy, 0);

    // Table of frames.
    for (int i = 0; i < 5; i++) begin
      run_frame(vt[i], $sformatf("vec%0d", i));
      repeat (3) @(negedge clock);
    end

    // Reset during data bit 3 of the third character.
    @(negedge clock);
    medida = 12'h123;
    enviar = 1'b1;
    target = 2 + 2 * STRIDE + 4 * D + 1;
    for (int n = 0; n <= target; n++) begin
      @(negedge clock);
      if (n == 0) enviar = 1'b0;
    end
    check("midrst line_before", int'(saida_serial), 0);
    #2 reset = 1'b1;
    #1;
    check("midrst line_async", int'(saida_serial), 1);
    check("midrst db_estado_async", int'(db_estado), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    npr = 0; lows = 0;
    for (int n = 0; n < WIN; n++) begin
      @(negedge clock);
      if (pronto === 1'b1) npr++;
      if (saida_serial !== 1'b1) lows++;
    end
    check("midrst no_pronto", npr, 0);
    check("midrst line_idle", lows, 0);
    begin
      vec_t v7;
      v7 = '{12'h007, 12'h007, 0, {8'h23, 8'h37, 8'h30, 8'h30}};
      run_frame(v7, "after_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
